// File: rtl/wide_spm_preloader.sv
// Streams a byte-wide program image into a wide scratchpad, packing bytes
// little-endian into rows, and releases the chip reset once the image is written.
module wide_spm_preloader #(
  parameter int SramDepth = 16384,
  parameter int SramWidth = 64,
  parameter int AddrWidth = $clog2(SramDepth)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   start_i,
  input  logic [7:0]             byte_i,
  input  logic                   byte_valid_i,
  input  logic                   byte_last_i,
  output logic                   byte_ready_o,
  output logic                   mem_req_o,
  input  logic                   mem_gnt_i,
  output logic [AddrWidth-1:0]   mem_addr_o,
  output logic [8*SramWidth-1:0] mem_wdata_o,
  output logic [SramWidth-1:0]   mem_be_o,
  output logic [AddrWidth:0]     words_o,
  output logic                   done_o,
  output logic                   error_o,
  output logic                   chip_rst_no
);

  localparam int LaneWidth = (SramWidth > 1) ? $clog2(SramWidth) : 1;
  localparam logic [LaneWidth-1:0] LastLane = LaneWidth'(SramWidth - 1);
  // The top row holds the exit-code word, so the last writable row is SramDepth-2.
  localparam logic [AddrWidth:0] ReservedRow = (AddrWidth + 1)'(SramDepth - 1);

  typedef enum logic [2:0] {IDLE, FILL, WRITE, DONE, ERR} state_e;

  state_e                 state_q, state_d;
  logic [8*SramWidth-1:0] buffer_q;
  logic [LaneWidth-1:0]   lane_q;
  logic [AddrWidth-1:0]   addr_q;
  logic [AddrWidth:0]     words_q;
  logic                   last_q;
  logic                   accept;
  logic                   write_done;

  assign accept     = byte_valid_i && (state_q == FILL);
  assign write_done = mem_gnt_i && (state_q == WRITE);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start_i) state_d = FILL;
      end
      FILL: begin
        if (accept && (byte_last_i || (lane_q == LastLane))) state_d = WRITE;
      end
      WRITE: begin
        if (mem_gnt_i) begin
          if (last_q) begin
            state_d = DONE;
          end else if (({1'b0, addr_q} + 1'b1) == ReservedRow) begin
            state_d = ERR;
          end else begin
            state_d = FILL;
          end
        end
      end
      DONE:    state_d = DONE;
      ERR:     state_d = ERR;
      default: state_d = IDLE;
    endcase
  end

  // A reset mid-row drops the partial buffer; rows already granted stay in memory.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      buffer_q <= '0;
      lane_q   <= '0;
      addr_q   <= '0;
      words_q  <= '0;
      last_q   <= 1'b0;
    end else begin
      if (accept) begin
        buffer_q[{lane_q, 3'b000} +: 8] <= byte_i;
        lane_q                          <= lane_q + 1'b1;
        last_q                          <= byte_last_i;
      end
      if (write_done) begin
        buffer_q <= '0;
        lane_q   <= '0;
        addr_q   <= addr_q + 1'b1;
        words_q  <= words_q + 1'b1;
      end
    end
  end

  assign byte_ready_o = (state_q == FILL);
  assign mem_req_o    = (state_q == WRITE);
  assign mem_addr_o   = addr_q;
  assign mem_wdata_o  = buffer_q;
  assign mem_be_o     = {SramWidth{mem_req_o}};
  assign words_o      = words_q;
  assign done_o       = (state_q == DONE);
  assign error_o      = (state_q == ERR);
  assign chip_rst_no  = (state_q == DONE);

endmodule

// File: tb/tb_wide_spm_preloader.sv
// Directed bench for wide_spm_preloader: full-size instance for image loads,
// plus a four-row instance for the capacity overflow case.
module tb_wide_spm_preloader;

  localparam int W   = 64;
  localparam int D   = 16384;
  localparam int AW  = $clog2(D);
  localparam int SD  = 4;
  localparam int SAW = $clog2(SD);

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start_i = 1'b0;
  logic [7:0]     byte_i = 8'h00;
  logic           byte_valid = 1'b0;
  logic           byte_last = 1'b0;
  logic           byte_ready;
  logic           mem_req;
  logic           mem_gnt = 1'b0;
  logic [AW-1:0]  mem_addr;
  logic [8*W-1:0] mem_wdata;
  logic [W-1:0]   mem_be;
  logic [AW:0]    words;
  logic           done;
  logic           error;
  logic           chip_rst_n;

  logic           sm_start = 1'b0;
  logic [7:0]     sm_byte = 8'h00;
  logic           sm_valid = 1'b0;
  logic           sm_last = 1'b0;
  logic           sm_ready;
  logic           sm_req;
  logic           sm_gnt = 1'b1;
  logic [SAW-1:0] sm_addr;
  logic [8*W-1:0] sm_wdata;
  logic [W-1:0]   sm_be;
  logic [SAW:0]   sm_words;
  logic           sm_done;
  logic           sm_error;
  logic           sm_chip_rst_n;

  int vectors = 0;
  int miscompares = 0;

  logic [AW-1:0]  cap_addr[$];
  logic [8*W-1:0] cap_data[$];
  logic [W-1:0]   cap_be[$];
  logic [SAW-1:0] sm_cap_addr[$];
  logic [8*W-1:0] sm_cap_data[$];

  wide_spm_preloader #(.SramDepth(D), .SramWidth(W)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start_i), .byte_i(byte_i),
    .byte_valid_i(byte_valid), .byte_last_i(byte_last), .byte_ready_o(byte_ready),
    .mem_req_o(mem_req), .mem_gnt_i(mem_gnt), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_be_o(mem_be), .words_o(words),
    .done_o(done), .error_o(error), .chip_rst_no(chip_rst_n)
  );

  wide_spm_preloader #(.SramDepth(SD), .SramWidth(W)) dut_small (
    .clk_i(clk), .rst_ni(rst_n), .start_i(sm_start), .byte_i(sm_byte),
    .byte_valid_i(sm_valid), .byte_last_i(sm_last), .byte_ready_o(sm_ready),
    .mem_req_o(sm_req), .mem_gnt_i(sm_gnt), .mem_addr_o(sm_addr),
    .mem_wdata_o(sm_wdata), .mem_be_o(sm_be), .words_o(sm_words),
    .done_o(sm_done), .error_o(sm_error), .chip_rst_no(sm_chip_rst_n)
  );

  always #5 clk = ~clk;

  // Inputs change just after posedge, so at negedge req&gnt means the write lands next edge.
  always @(negedge clk) begin
    if (mem_req && mem_gnt) begin
      cap_addr.push_back(mem_addr);
      cap_data.push_back(mem_wdata);
      cap_be.push_back(mem_be);
    end
    if (sm_req && sm_gnt) begin
      sm_cap_addr.push_back(sm_addr);
      sm_cap_data.push_back(sm_wdata);
    end
  end

  task automatic do_reset;
    rst_n = 1'b0;
    start_i = 1'b0;
    byte_valid = 1'b0;
    byte_last = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    cap_addr.delete();
    cap_data.delete();
    cap_be.delete();
  endtask

  task automatic pulse_start;
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic last);
    int n = 0;
    byte_i = b;
    byte_valid = 1'b1;
    byte_last = last;
    @(negedge clk);
    while (!byte_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!byte_ready) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL ready_timeout: byte_ready got %0b, expected 1 within 200 cycles", byte_ready);
    end
    @(posedge clk); #1;
    byte_valid = 1'b0;
    byte_last = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if ({byte_ready, mem_req, done, error, chip_rst_n} !== 5'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_flags: got %b, expected 00000", {byte_ready, mem_req, done, error, chip_rst_n});
    end
    vectors++;
    if (words !== '0 || mem_addr !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_counters: got words=%0d addr=%0d, expected 0/0", words, mem_addr);
    end
    vectors++;
    if (mem_wdata !== '0 || mem_be !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_data: got be=%h, expected 0 with zero wdata", mem_be);
    end
    vectors++;
    if ({sm_ready, sm_req, sm_done, sm_error, sm_chip_rst_n} !== 5'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_small: got %b, expected 00000", {sm_ready, sm_req, sm_done, sm_error, sm_chip_rst_n});
    end
    do_reset();
  endtask

  task automatic test_full_image;
    logic [8*W-1:0] exp0, exp1, got;
    for (int k = 0; k < W; k++) begin
      exp0[8*k +: 8] = 8'(k);
      exp1[8*k +: 8] = 8'(k + 64);
    end
    do_reset();
    mem_gnt = 1'b1;
    pulse_start();
    for (int i = 0; i < 128; i++) send_byte(8'(i), i == 127);
    vectors++;
    if (mem_req !== 1'b1 || done !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL full_req_latency: got req=%0b done=%0b, expected 1/0", mem_req, done);
    end
    @(posedge clk); #1;
    vectors++;
    if (done !== 1'b1 || chip_rst_n !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL full_done_latency: got done=%0b chip_rst_n=%0b, expected 1/1", done, chip_rst_n);
    end
    vectors++;
    if (cap_data.size() != 2 || words !== 15'd2) begin
      miscompares++;
      $display("[TB] FAIL full_count: got writes=%0d words=%0d, expected 2/2", cap_data.size(), words);
    end
    got = (cap_data.size() > 0) ? cap_data[0] : '0;
    vectors++;
    if (got !== exp0 || cap_addr.size() < 1 || cap_addr[0] !== '0) begin
      miscompares++;
      $display("[TB] FAIL full_row0: got %h, expected %h", got, exp0);
    end
    got = (cap_data.size() > 1) ? cap_data[1] : '0;
    vectors++;
    if (got !== exp1 || cap_addr.size() < 2 || cap_addr[1] !== 14'd1) begin
      miscompares++;
      $display("[TB] FAIL full_row1: got %h, expected %h", got, exp1);
    end
  endtask

  task automatic test_partial_row;
    logic [8*W-1:0] exp1, got;
    exp1 = {504'h0, 8'h40};
    do_reset();
    mem_gnt = 1'b1;
    pulse_start();
    for (int i = 0; i < 65; i++) send_byte(8'(i), i == 64);
    @(posedge clk); #1;
    got = (cap_data.size() > 1) ? cap_data[1] : '0;
    vectors++;
    if (got !== exp1) begin
      miscompares++;
      $display("[TB] FAIL partial_row1: got %h, expected %h", got, exp1);
    end
    vectors++;
    if (cap_be.size() < 2 || cap_be[1] !== {W{1'b1}}) begin
      miscompares++;
      $display("[TB] FAIL partial_be: got %0d captured enables, expected 2 all-ones", cap_be.size());
    end
    vectors++;
    if (words !== 15'd2 || done !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL partial_words: got words=%0d done=%0b, expected 2/1", words, done);
    end
  endtask

  task automatic test_grant_stall;
    logic [8*W-1:0] exp;
    for (int k = 0; k < W; k++) exp[8*k +: 8] = 8'(k) ^ 8'h5A;
    do_reset();
    mem_gnt = 1'b0;
    pulse_start();
    for (int i = 0; i < W; i++) send_byte(8'(i) ^ 8'h5A, 1'b0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      vectors++;
      if (mem_req !== 1'b1 || mem_addr !== '0 || mem_wdata !== exp || byte_ready !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL stall_hold_%0d: got req=%0b addr=%0d ready=%0b, expected 1/0/0 with stable row",
                 c, mem_req, mem_addr, byte_ready);
      end
    end
    @(posedge clk); #1;
    mem_gnt = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    vectors++;
    if (cap_data.size() != 1 || words !== 15'd1 || byte_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL stall_single_write: got writes=%0d words=%0d ready=%0b, expected 1/1/1",
               cap_data.size(), words, byte_ready);
    end
    vectors++;
    if (cap_data.size() < 1 || cap_data[0] !== exp) begin
      miscompares++;
      $display("[TB] FAIL stall_row0: got %0d writes, expected row 0 = %h", cap_data.size(), exp);
    end
  endtask

  task automatic test_capacity_overflow;
    int idx = 0;
    logic acc;
    logic [8*W-1:0] exp2, got;
    for (int k = 0; k < W; k++) exp2[8*k +: 8] = 8'(128 + k);
    sm_start = 1'b1;
    @(posedge clk); #1;
    sm_start = 1'b0;
    sm_byte = 8'h00;
    sm_valid = 1'b1;
    sm_last = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      acc = sm_ready;
      @(posedge clk); #1;
      if (acc) idx++;
      sm_byte = 8'(idx);
      sm_last = (idx == 4 * W - 1);
    end
    sm_valid = 1'b0;
    vectors++;
    if (sm_error !== 1'b1 || sm_chip_rst_n !== 1'b0 || sm_done !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL overflow_flags: got err=%0b chip_rst_n=%0b done=%0b, expected 1/0/0",
               sm_error, sm_chip_rst_n, sm_done);
    end
    vectors++;
    if (sm_words !== 3'd3 || sm_cap_addr.size() != 3 || idx != 192) begin
      miscompares++;
      $display("[TB] FAIL overflow_count: got words=%0d writes=%0d bytes=%0d, expected 3/3/192",
               sm_words, sm_cap_addr.size(), idx);
    end
    vectors++;
    if (sm_req !== 1'b0 || sm_ready !== 1'b0 || (sm_cap_addr.size() > 2 && sm_cap_addr[2] !== 2'd2)) begin
      miscompares++;
      $display("[TB] FAIL overflow_stop: got req=%0b ready=%0b, expected 0/0 with last row 2", sm_req, sm_ready);
    end
    got = (sm_cap_data.size() > 2) ? sm_cap_data[2] : '0;
    vectors++;
    if (got !== exp2) begin
      miscompares++;
      $display("[TB] FAIL overflow_row2: got %h, expected %h", got, exp2);
    end
  endtask

  task automatic test_mid_load_reset;
    logic [8*W-1:0] exp, got;
    exp = '0;
    exp[23:0] = 24'hC3C2C1;
    do_reset();
    mem_gnt = 1'b1;
    pulse_start();
    for (int i = 0; i < 30; i++) send_byte(8'(i + 1), 1'b0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    byte_i = 8'hEE;
    byte_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    byte_valid = 1'b0;
    vectors++;
    if (byte_ready !== 1'b0 || mem_req !== 1'b0 || words !== '0 || cap_data.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL midreset_idle: got ready=%0b req=%0b words=%0d writes=%0d, expected 0/0/0/0",
               byte_ready, mem_req, words, cap_data.size());
    end
    pulse_start();
    send_byte(8'hC1, 1'b0);
    send_byte(8'hC2, 1'b0);
    send_byte(8'hC3, 1'b1);
    @(posedge clk); #1;
    got = (cap_data.size() > 0) ? cap_data[0] : '0;
    vectors++;
    if (got !== exp || cap_data.size() != 1 || done !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL midreset_restart: got %h, expected %h", got, exp);
    end
  endtask

  task automatic test_gaps_and_starts;
    logic [8*W-1:0] exp0, exp1, got0, got1;
    int gap;
    exp1 = '0;
    for (int k = 0; k < W; k++) exp0[8*k +: 8] = 8'(3 * k + 7);
    for (int k = 0; k < 36; k++) exp1[8*k +: 8] = 8'(3 * (k + 64) + 7);
    do_reset();
    mem_gnt = 1'b1;
    pulse_start();
    for (int i = 0; i < 100; i++) begin
      gap = $urandom_range(0, 3);
      repeat (gap) begin
        start_i = 1'b1;
        @(posedge clk); #1;
      end
      start_i = 1'b0;
      send_byte(8'(3 * i + 7), i == 99);
    end
    @(posedge clk); #1;
    got0 = (cap_data.size() > 0) ? cap_data[0] : '0;
    got1 = (cap_data.size() > 1) ? cap_data[1] : '0;
    vectors++;
    if (got0 !== exp0) begin
      miscompares++;
      $display("[TB] FAIL gaps_row0: got %h, expected %h", got0, exp0);
    end
    vectors++;
    if (got1 !== exp1) begin
      miscompares++;
      $display("[TB] FAIL gaps_row1: got %h, expected %h", got1, exp1);
    end
    vectors++;
    if (words !== 15'd2 || cap_data.size() != 2 || done !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL gaps_count: got words=%0d writes=%0d done=%0b, expected 2/2/1",
               words, cap_data.size(), done);
    end
  endtask

  initial begin
    test_reset();
    test_full_image();
    test_partial_row();
    test_grant_stall();
    test_capacity_overflow();
    test_mid_load_reset();
    test_gaps_and_starts();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
